// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-look-ahead subtractor.
// Latency: none (definitions only).
// Backpressure: not applicable.
package cla_pkg;

  localparam int CLA_GROUP     = 4;
  localparam int CLA_WIDTH_DEF = 16;
  localparam int CLA_SPLIT_DEF = 8;
  // Widest slice is_zero() accepts; callers zero-extend narrower slices.
  localparam int CLA_ZW        = 64;

  function automatic logic is_zero(input logic [CLA_ZW-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/cla_block4.sv
// 4-bit generate/propagate adder cell with group generate/propagate outputs.
// Latency: combinational.
// Backpressure: not applicable.
module cla_block4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] sum,
  output logic                 grp_g,
  output logic                 grp_p
);

  logic [CLA_GROUP-1:0] gen;
  logic [CLA_GROUP-1:0] prop;
  logic [CLA_GROUP-1:0] carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Carries flattened so no bit waits on a ripple inside the cell.
  assign carry[0] = cin;
  assign carry[1] = gen[0] | (prop[0] & cin);
  assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
  assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                  | (prop[2] & prop[1] & prop[0] & cin);

  assign sum = prop ^ carry;

  // Group terms deliberately exclude cin so the look-ahead unit sees no loop.
  assign grp_g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
               | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign grp_p = &prop;

endmodule

// File: rtl/cla_group_adder.sv
// W-bit adder built from 4-bit CLA cells joined by a flattened group look-ahead unit.
// Latency: combinational.
// Backpressure: not applicable.
module cla_group_adder
  import cla_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int NG = W / CLA_GROUP;

  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   gc;
  logic          term_p;
  logic          carry;

  for (genvar gi = 0; gi < NG; gi++) begin : g_blk
    cla_block4 u_blk (
      .a     (a[gi*CLA_GROUP +: CLA_GROUP]),
      .b     (b[gi*CLA_GROUP +: CLA_GROUP]),
      .cin   (gc[gi]),
      .sum   (sum[gi*CLA_GROUP +: CLA_GROUP]),
      .grp_g (grp_g[gi]),
      .grp_p (grp_p[gi])
    );
  end

  // gc[k+1] = G[k] | P[k]G[k-1] | ... | P[k..0]cin, each as a two-level AND-OR.
  always_comb begin
    gc     = '0;
    term_p = 1'b0;
    carry  = 1'b0;
    gc[0]  = cin;
    for (int k = 0; k < NG; k++) begin
      carry  = 1'b0;
      term_p = 1'b1;
      for (int j = NG - 1; j >= 0; j--) begin
        if (j <= k) begin
          carry  = carry | (term_p & grp_g[j]);
          term_p = term_p & grp_p[j];
        end
      end
      gc[k+1] = carry | (term_p & cin);
    end
  end

  assign cout = gc[NG];

endmodule

// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined A - B - Bin via A + ~B + ~Bin on CLA groups, with borrow/overflow/zero flags.
// Latency: 2 cycles from input accept to out_valid when out_ready is held high.
// Backpressure: valid/ready both sides, in_ready combinational from out_ready, no skid buffer.
module cla_subtractor_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH_DEF,
  parameter int SPLIT = CLA_SPLIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int HI = WIDTH - SPLIT;

  logic             s1_vld_q, s1_vld_d;
  logic             s2_vld_q, s2_vld_d;
  logic [SPLIT-1:0] s1_lo_q, s1_lo_d;
  logic             s1_c_q, s1_c_d;
  logic [HI-1:0]    s1_a_hi_q, s1_a_hi_d;
  logic [HI-1:0]    s1_b_hi_q, s1_b_hi_d;
  logic             s1_a_msb_q, s1_a_msb_d;
  logic             s1_b_msb_q, s1_b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             s1_adv, s2_adv;
  logic             s1_load, s2_load;
  logic [SPLIT-1:0] b_lo_n;
  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic [HI-1:0]    b_hi_n;
  logic [HI-1:0]    hi_sum;
  logic             hi_cout;

  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign in_ready = s1_adv;
  assign s1_load  = in_valid && s1_adv;
  assign s2_load  = s1_vld_q && s2_adv;

  assign b_lo_n = ~B[SPLIT-1:0];
  assign b_hi_n = ~s1_b_hi_q;

  cla_group_adder #(.W(SPLIT)) u_lo (
    .a    (A[SPLIT-1:0]),
    .b    (b_lo_n),
    .cin  (~Bin),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  cla_group_adder #(.W(HI)) u_hi (
    .a    (s1_a_hi_q),
    .b    (b_hi_n),
    .cin  (s1_c_q),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_comb begin
    s1_vld_d   = s1_adv ? in_valid : s1_vld_q;
    s2_vld_d   = s2_adv ? s1_vld_q : s2_vld_q;
    s1_lo_d    = s1_lo_q;
    s1_c_d     = s1_c_q;
    s1_a_hi_d  = s1_a_hi_q;
    s1_b_hi_d  = s1_b_hi_q;
    s1_a_msb_d = s1_a_msb_q;
    s1_b_msb_d = s1_b_msb_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;

    if (s1_load) begin
      s1_lo_d    = lo_sum;
      s1_c_d     = lo_cout;
      s1_a_hi_d  = A[WIDTH-1:SPLIT];
      s1_b_hi_d  = B[WIDTH-1:SPLIT];
      s1_a_msb_d = A[WIDTH-1];
      s1_b_msb_d = B[WIDTH-1];
    end

    // A carry out of A + ~B + ~Bin means no borrow was needed.
    if (s2_load) begin
      diff_d = {hi_sum, s1_lo_q};
      bout_d = ~hi_cout;
      ovf_d  = (s1_a_msb_q != s1_b_msb_q) && (hi_sum[HI-1] != s1_a_msb_q);
      zero_d = is_zero(CLA_ZW'(s1_lo_q)) && is_zero(CLA_ZW'(hi_sum));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s1_lo_q    <= '0;
      s1_c_q     <= 1'b0;
      s1_a_hi_q  <= '0;
      s1_b_hi_q  <= '0;
      s1_a_msb_q <= 1'b0;
      s1_b_msb_q <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      s1_lo_q    <= s1_lo_d;
      s1_c_q     <= s1_c_d;
      s1_a_hi_q  <= s1_a_hi_d;
      s1_b_hi_q  <= s1_b_hi_d;
      s1_a_msb_q <= s1_a_msb_d;
      s1_b_msb_q <= s1_b_msb_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign Diff      = diff_q;
  assign Bout      = bout_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Scoreboard bench for cla_subtractor_pipe: directed vectors, stall, reset and random traffic.
module tb_cla_subtractor_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Diff;
  logic        Bout;
  logic        Ovf;
  logic        Zero;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[10];
  int   checks   = 0;
  int   failures = 0;
  int   n_in     = 0;
  int   n_out    = 0;
  bit   rnd_en   = 1'b0;

  cla_subtractor_pipe #(.WIDTH(16), .SPLIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (Diff),
    .Bout      (Bout),
    .Ovf       (Ovf),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] full;
    exp_t        e;
    full   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    e.diff = full[15:0];
    e.bout = full[16];
    e.ovf  = (a[15] != b[15]) && (e.diff[15] != a[15]);
    e.zero = (e.diff == 16'h0000);
    return e;
  endfunction

  function automatic exp_t vexp(input vec_t v);
    exp_t e;
    e.diff = v.diff;
    e.bout = v.bout;
    e.ovf  = v.ovf;
    e.zero = v.zero;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the accept edge with in_valid low.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin, input exp_t e);
    int n;
    bit acc;
    n   = 0;
    acc = 1'b0;
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    while (!acc && n < 500) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else begin
        n++;
        tick();
      end
    end
    if (acc) begin
      exp_q.push_back(e);
      n_in++;
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rnd_en    = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=no_output", Diff);
        end else begin
          e = exp_q.pop_front();
          chk("result", {13'd0, Diff, Bout, Ovf, Zero}, {13'd0, e});
          n_out++;
        end
      end
    end
  endtask

  initial begin
    //           a         b         bin   diff      bout  ovf   zero
    vecs[0] = '{16'h5678, 16'h1234, 1'b0, 16'h4444, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h0100, 16'h00FF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; out_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", {13'd0, Diff, Bout, Ovf, Zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Latency with out_ready high
    send(vecs[0].a, vecs[0].b, vecs[0].bin, vexp(vecs[0]));
    @(negedge clk);
    chk("lat_cycle1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_out_valid", 32'(out_valid), 32'd1);
    tick();

    // Back-to-back directed vectors
    for (int i = 1; i < 10; i++) send(vecs[i].a, vecs[i].b, vecs[i].bin, vexp(vecs[i]));
    drain();

    // Stall: two accepts fill the pipe, third op waits
    out_ready = 1'b0;
    A = vecs[3].a; B = vecs[3].b; Bin = vecs[3].bin; in_valid = 1'b1;
    @(negedge clk);
    chk("stall_accept1_rdy", 32'(in_ready), 32'd1);
    exp_q.push_back(vexp(vecs[3])); n_in++;
    tick();
    A = vecs[5].a; B = vecs[5].b; Bin = vecs[5].bin;
    @(negedge clk);
    chk("stall_accept2_rdy", 32'(in_ready), 32'd1);
    exp_q.push_back(vexp(vecs[5])); n_in++;
    tick();
    A = vecs[0].a; B = vecs[0].b; Bin = vecs[0].bin;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_hold", {13'd0, Diff, Bout, Ovf, Zero}, {13'd0, vexp(vecs[3])});
      tick();
    end
    out_ready = 1'b1;
    exp_q.push_back(vexp(vecs[0])); n_in++;
    @(negedge clk);
    chk("release_out1", 32'(out_valid), 32'd1);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_out2", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("release_out3", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("release_out_empty", 32'(out_valid), 32'd0);
    chk("release_queue", 32'(exp_q.size()), 32'd0);
    tick();

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    A = vecs[3].a; B = vecs[3].b; Bin = vecs[3].bin; in_valid = 1'b1;
    tick();
    A = vecs[5].a; B = vecs[5].b; Bin = vecs[5].bin;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_outputs", {13'd0, Diff, Bout, Ovf, Zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    tick();
    send(vecs[6].a, vecs[6].b, vecs[6].bin, vexp(vecs[6]));
    @(negedge clk);
    chk("rst2_lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("rst2_lat_cycle2", 32'(out_valid), 32'd1);
    tick();

    // Random traffic against the arithmetic model
    rnd_en = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rbin;
      if ($urandom_range(0, 2) == 0) tick();
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      if (i % 16 == 0) rb = ra;
      send(ra, rb, rbin, model(ra, rb, rbin));
    end
    drain();
    chk("count_in_eq_out", 32'(n_out), 32'(n_in));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
